// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage MIPS pipeline: forwarding selects,
// stall/flush strobes, multi-cycle op sequencing and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             MdStartE,
    input  logic             MemReqM,
    input  logic             MemRdyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic {StIdle, StBusy} md_state_e;

    localparam logic [3:0] MdInit = 4'(MUL_LAT - 1);

    md_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_ae, fwd_be;
    logic       fwd_ad, fwd_bd;
    logic       lwstall, branchstall, memstall, mdstall;
    logic       stall_e, stall_fd;

    always_comb begin
        fwd_ae = 2'b00;
        if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE) begin
            fwd_ae = 2'b10;
        end else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) begin
            fwd_ae = 2'b01;
        end
        fwd_be = 2'b00;
        if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE) begin
            fwd_be = 2'b10;
        end else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) begin
            fwd_be = 2'b01;
        end
    end

    assign fwd_ad = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
    assign fwd_bd = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

    assign lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    assign branchstall = BranchD &&
        ((RegWriteE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
         (MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD)));
    assign memstall    = MemReqM && !MemRdyM;
    assign mdstall     = ((state_q == StIdle) && MdStartE) ||
                         ((state_q == StBusy) && (cnt_q != 4'd0));

    assign stall_e  = memstall || mdstall;
    assign stall_fd = stall_e || lwstall || branchstall;

    // Every strobe and select is held at zero while reset is asserted.
    assign StallM    = clr && memstall;
    assign StallE    = clr && stall_e;
    assign StallF    = clr && stall_fd;
    assign StallD    = clr && stall_fd;
    assign FlushM    = clr && mdstall && !memstall;
    assign FlushE    = clr && (lwstall || branchstall) && !stall_e;
    assign FlushD    = clr && PCSrcD && !stall_fd;
    assign ForwardAE = clr ? fwd_ae : 2'b00;
    assign ForwardBE = clr ? fwd_be : 2'b00;
    assign ForwardAD = clr && fwd_ad;
    assign ForwardBD = clr && fwd_bd;
    assign MdBusy    = clr && (state_q == StBusy);
    assign StallCycles = stall_cnt_q;

    // The sequencer keeps counting through memory wait states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (MdStartE) begin
                    state_d = StBusy;
                    cnt_d   = MdInit;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a MUL_LAT=1, CNT_W=4
// instance for the single-cycle op and counter saturation cases.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MdStartE, MemReqM, MemRdyM;

    logic        sf1, sd1, se1, sm1, fd1, fe1, fm1, fad1, fbd1, busy1;
    logic [1:0]  fae1, fbe1;
    logic [15:0] cnt1;
    logic        sf2, sd2, se2, sm2, fd2, fe2, fm2, fad2, fbd2, busy2;
    logic [1:0]  fae2, fbe2;
    logic [3:0]  cnt2;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .clr(clr), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MdStartE(MdStartE), .MemReqM(MemReqM), .MemRdyM(MemRdyM),
        .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
        .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
        .ForwardAE(fae1), .ForwardBE(fbe1), .ForwardAD(fad1), .ForwardBD(fbd1),
        .MdBusy(busy1), .StallCycles(cnt1)
    );

    hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) dut2 (
        .clk(clk), .clr(clr), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MdStartE(MdStartE), .MemReqM(MemReqM), .MemRdyM(MemRdyM),
        .StallF(sf2), .StallD(sd2), .StallE(se2), .StallM(sm2),
        .FlushD(fd2), .FlushE(fe2), .FlushM(fm2),
        .ForwardAE(fae2), .ForwardBE(fbe2), .ForwardAD(fad2), .ForwardBD(fbd2),
        .MdBusy(busy2), .StallCycles(cnt2)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic [13:0] exp;
        logic [15:0] ecnt;
        bit          chk_cnt;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [15:0] model1 = '0;
    logic [3:0]  model2 = '0;

    localparam logic [13:0] Zero = 14'd0;

    // Packs outputs as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,AE,BE,AD,BD,MdBusy}.
    function automatic logic [13:0] ex(input logic sf, sd, se, sm, fd, fe, fm,
                                       input logic [1:0] fae, fbe,
                                       input logic fad, fbd, busy);
        return {sf, sd, se, sm, fd, fe, fm, fae, fbe, fad, fbd, busy};
    endfunction

    task automatic clear_in();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0;
        MdStartE = 0; MemReqM = 0; MemRdyM = 0;
    endtask

    task automatic step(input string tag, input bit sel, input logic [13:0] e,
                        input bit chk_cnt);
        item_t       it;
        logic [13:0] obs;
        logic [15:0] ocnt;
        it.tag = tag; it.sel = sel; it.exp = e; it.chk_cnt = chk_cnt;
        it.ecnt = sel ? {12'd0, model2} : model1;
        sb.push_back(it);
        @(negedge clk);
        it = sb.pop_front();
        if (it.sel) begin
            obs  = {sf2, sd2, se2, sm2, fd2, fe2, fm2, fae2, fbe2, fad2, fbd2, busy2};
            ocnt = {12'd0, cnt2};
        end else begin
            obs  = {sf1, sd1, se1, sm1, fd1, fe1, fm1, fae1, fbe1, fad1, fbd1, busy1};
            ocnt = cnt1;
        end
        checks++;
        assert (obs === it.exp) passes++;
        else $error("FAIL %s outputs observed=%b expected=%b", it.tag, obs, it.exp);
        if (it.chk_cnt) begin
            checks++;
            assert (ocnt === it.ecnt) passes++;
            else $error("FAIL %s StallCycles observed=%0d expected=%0d",
                        it.tag, ocnt, it.ecnt);
        end
        if (!clr) begin
            model1 = '0;
            model2 = '0;
        end else if (e[13]) begin
            if (sel) begin
                if (model2 != 4'hf) model2 = model2 + 4'd1;
            end else if (model1 != 16'hffff) begin
                model1 = model1 + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        clr = 1'b0;
        MemReqM = 1'b1;
        @(posedge clk);
        #1;
        step("reset_forced_zero", 0, Zero, 1);
        clr = 1'b1;
        clear_in();

        RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
        step("fwd_ae_mem", 0, ex(0,0,0,0,0,0,0,2'b10,2'b00,0,0,0), 1);
        RegWriteM = 0;
        step("fwd_ae_wb", 0, ex(0,0,0,0,0,0,0,2'b01,2'b00,0,0,0), 1);
        RsE = 0; RtE = 9; WriteRegM = 9; RegWriteM = 1; WriteRegW = 0; RsD = 9;
        step("fwd_r0_be_ad", 0, ex(0,0,0,0,0,0,0,2'b00,2'b10,1,0,0), 1);
        RsD = 0; RtD = 9;
        step("fwd_bd", 0, ex(0,0,0,0,0,0,0,2'b00,2'b10,0,1,0), 1);

        clear_in();
        MemtoRegE = 1; RtE = 8; RsD = 8;
        step("load_use", 0, ex(1,1,0,0,0,1,0,2'b00,2'b00,0,0,0), 1);
        clear_in();
        step("load_gone", 0, Zero, 1);

        MdStartE = 1;
        step("md_entry", 0, ex(1,1,1,0,0,0,1,2'b00,2'b00,0,0,0), 1);
        for (int i = 0; i < 3; i++) begin
            step("md_busy", 0, ex(1,1,1,0,0,0,1,2'b00,2'b00,0,0,1), 1);
        end
        step("md_release", 0, ex(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1), 1);
        step("md_retrigger", 0, ex(1,1,1,0,0,0,1,2'b00,2'b00,0,0,0), 1);
        step("md_busy_cnt3", 0, ex(1,1,1,0,0,0,1,2'b00,2'b00,0,0,1), 1);
        clr = 1'b0;
        step("md_reset_busy", 0, Zero, 1);
        clr = 1'b1;
        MdStartE = 0;
        step("md_after_reset", 0, Zero, 1);

        MemReqM = 1; MemRdyM = 0; MemtoRegE = 1; RtE = 8; RsD = 8;
        for (int i = 0; i < 3; i++) begin
            step("mem_wait_lw", 0, ex(1,1,1,1,0,0,0,2'b00,2'b00,0,0,0), 1);
        end
        MemRdyM = 1;
        step("mem_rdy_lw", 0, ex(1,1,0,0,0,1,0,2'b00,2'b00,0,0,0), 1);
        clear_in();
        step("mem_done", 0, Zero, 1);

        BranchD = 1; PCSrcD = 1;
        step("br_taken", 0, ex(0,0,0,0,1,0,0,2'b00,2'b00,0,0,0), 1);
        RegWriteE = 1; WriteRegE = 3; RsD = 3;
        step("br_stall_e", 0, ex(1,1,0,0,0,1,0,2'b00,2'b00,0,0,0), 1);
        RegWriteE = 0; WriteRegE = 0; RsD = 0; MemtoRegM = 1; WriteRegM = 4; RtD = 4;
        step("br_stall_m", 0, ex(1,1,0,0,0,1,0,2'b00,2'b00,0,0,0), 1);
        MemtoRegM = 0; WriteRegM = 0; RtD = 0; RegWriteE = 1;
        step("br_r0_nostall", 0, ex(0,0,0,0,1,0,0,2'b00,2'b00,0,0,0), 1);

        clear_in();
        MemReqM = 1; MdStartE = 1;
        step("memmd_entry", 0, ex(1,1,1,1,0,0,0,2'b00,2'b00,0,0,0), 1);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            step("memmd_busy", 0, ex(1,1,1,0,0,0,1,2'b00,2'b00,0,0,1), 1);
        end
        step("memmd_release", 0, ex(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1), 1);
        step("memmd_idle", 0, Zero, 1);

        clr = 1'b0;
        step("lat1_reset", 1, Zero, 0);
        clr = 1'b1;
        MdStartE = 1;
        step("lat1_entry", 1, ex(1,1,1,0,0,0,1,2'b00,2'b00,0,0,0), 1);
        step("lat1_release", 1, ex(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1), 1);
        MdStartE = 0;
        step("lat1_idle", 1, Zero, 1);
        MemReqM = 1;
        for (int i = 0; i < 18; i++) begin
            step("sat_memwait", 1, ex(1,1,1,1,0,0,0,2'b00,2'b00,0,0,0), 1);
        end
        MemReqM = 0;
        step("sat_hold", 1, Zero, 1);
        step("sat_hold2", 1, Zero, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It generates the forwarding selects for the Decode and Execute stages, the stall and flush strobes for the IF/ID, ID/EX and EX/MEM pipeline registers, and sequences multi-cycle multiply/divide operations held in Execute. It also sequences data-memory wait states and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_LAT, default 4: stall cycles inserted for a multi-cycle op in Execute; legal range 1–15.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset: one clock; reset is synchronous and active-low.
- RsD, RtD  in  5 each  source registers in Decode.
- RsE, RtE  in  5 each  source registers in Execute.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage.
- MemtoRegE, MemtoRegM  in  1 each  load in stage.
- BranchD  in  1  branch in Decode.
- PCSrcD  in  1  branch taken.
- MdStartE  in  1  multi-cycle op in Execute.
- MemReqM  in  1  memory access in Memory stage.
- MemRdyM  in  1  memory ready.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushM  out  1 each  clear IF/ID, ID/EX and EX/MEM.
- ForwardAE, ForwardBE  out  2 each  ALU operand selects: 00 = register file, 01 = Writeback result, 10 = Memory-stage ALU result.
- ForwardAD, ForwardBD  out  1 each  branch comparator takes the Memory-stage ALU result.
- MdBusy  out  1  multi-cycle FSM is in BUSY.
- StallCycles  out  CNT_W  count of cycles with StallF=1.

## Operation
- Forwarding is combinational, and register 0 is never forwarded.
  - ForwardAE = 10 when RsE≠0, RegWriteM=1 and WriteRegM=RsE.
  - Otherwise ForwardAE = 01 when RsE≠0, RegWriteW=1 and WriteRegW=RsE.
  - Otherwise ForwardAE = 00. ForwardBE follows the same rules using RtE.
  - ForwardAD = (RsD≠0 and RegWriteM and WriteRegM=RsD). ForwardBD follows the same rule using RtD.
- Hazard terms:
  - lwstall = MemtoRegE and (RtE=RsD or RtE=RtD).
  - branchstall = BranchD and one of:
    - RegWriteE and WriteRegE≠0 and WriteRegE∈{RsD,RtD};
    - MemtoRegM and WriteRegM≠0 and WriteRegM∈{RsD,RtD}.
  - memstall = MemReqM and not MemRdyM.
- Multi-cycle FSM (registered state plus a 4-bit counter cnt):
  - IDLE: when MdStartE=1, load cnt ← MUL_LAT−1 and go to BUSY.
  - BUSY: when cnt≠0, decrement cnt; when cnt=0, go to IDLE.
  - The FSM advances during memstall; the functional unit runs independently.
  - mdstall = (IDLE and MdStartE) or (BUSY and cnt≠0).
- Output equations:
  - StallM = memstall.
  - StallE = memstall or mdstall.
  - StallF = StallD = StallE or lwstall or branchstall.
  - FlushM = mdstall and not memstall, which injects a bubble behind the held op.
  - FlushE = (lwstall or branchstall) and not StallE.
  - FlushD = PCSrcD and not StallD.
- Priority: memstall > mdstall > lwstall/branchstall > branch flush. A held stage is never flushed in the same cycle.
- StallCycles increments on each cycle with StallF=1 and saturates at all-ones.

## Timing
- Reset: while clr=0 at a clock edge, state ← IDLE, cnt ← 0 and StallCycles ← 0.
- While clr=0, every stall, flush and forward output is forced to 0 and MdBusy=0.
- Reset during BUSY abandons the op. There is no completion.
- A multi-cycle op causes exactly MUL_LAT stall cycles and stays in Execute for MUL_LAT+1 cycles.
  - On the release cycle (BUSY, cnt=0) StallE=0.
  - MdStartE still high on the release cycle does not retrigger, because BUSY ignores it.
  - The next op retriggers from IDLE on the following cycle.
- MUL_LAT=1: one stall cycle (the IDLE entry cycle), then a single release cycle in BUSY.
- memstall is combinational and releases in the same cycle MemRdyM rises.
- lwstall produces exactly one stall cycle, because the load leaves Execute.

## Test plan
- Forwarding:
  - RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 → ForwardAE=10.
  - Dropping RegWriteM → ForwardAE=01.
  - RsE=0 → ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for one cycle; StallCycles=1.
- Multiply with MUL_LAT=4, MdStartE held high while StallE=1:
  - StallE=1 for 4 cycles and FlushM=1 for 4 cycles.
  - MdBusy=1 for 4 cycles starting the cycle after entry.
  - Release cycle has StallE=0.
- Memory wait: MemReqM=1 with MemRdyM low for 3 cycles → StallF/D/E/M=1 for 3 cycles and FlushE=0 throughout, even with lwstall conditions present.
- Branch: PCSrcD=1, no hazards → FlushD=1. Repeat with branchstall (WriteRegE=RsD, RegWriteE=1) → FlushD=0 and FlushE=1.
- Reset mid-BUSY (clr=0 for one cycle at cnt=2) → next cycle IDLE, MdBusy=0, StallCycles=0; the saturation check with CNT_W=4 holds at 15.
